// File: rtl/tick_period_meter.sv
// Tick period meter: measures clk cycles between tick rises,
// tracks lock against an expected period and flags missing ticks.
module tick_period_meter #(
  parameter int CNT_WIDTH      = 31,
  parameter int EXPECTED       = 315000,
  parameter int TOLERANCE      = 16,
  parameter int LOCK_COUNT     = 4,
  parameter int TIMEOUT_CYCLES = 630000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_in,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 in_tol,
  output logic                 locked,
  output logic                 timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_WIDTH-1:0] EXP_C = CNT_WIDTH'(EXPECTED);
  localparam logic [CNT_WIDTH-1:0] TOL_C = CNT_WIDTH'(TOLERANCE);
  localparam logic [CNT_WIDTH-1:0] TMO_C = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [MW-1:0]        LCK_C = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [MW-1:0]        match_cnt;
  logic                 tick_q;

  logic                 rise;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] diff;
  logic                 tol_ok;
  logic [MW-1:0]        match_nxt;

  // Rise detect and candidate measurement for the current cycle
  always_comb begin
    rise    = tick_in & ~tick_q;
    cnt_inc = cnt + 1'b1;
    if (cnt_inc >= EXP_C) begin
      diff = cnt_inc - EXP_C;
    end else begin
      diff = EXP_C - cnt_inc;
    end
    tol_ok = (diff <= TOL_C);
    if (!tol_ok) begin
      match_nxt = '0;
    end else if (match_cnt >= LCK_C) begin
      match_nxt = LCK_C;
    end else begin
      match_nxt = match_cnt + 1'b1;
    end
  end

  // Edge register, measurement FSM and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      match_cnt    <= '0;
      tick_q       <= 1'b0;
      period_out   <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      tick_q       <= tick_in;
      period_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rise) begin
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_out   <= cnt_inc;
            period_valid <= 1'b1;
            in_tol       <= tol_ok;
            match_cnt    <= match_nxt;
            locked       <= (match_nxt == LCK_C);
            cnt          <= '0;
          end else if (cnt_inc == TMO_C) begin
            state     <= TIMEOUT;
            timeout   <= 1'b1;
            locked    <= 1'b0;
            in_tol    <= 1'b0;
            match_cnt <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        TIMEOUT: begin
          if (rise) begin
            timeout <= 1'b0;
            cnt     <= '0;
            state   <= MEASURE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed testbench for tick_period_meter with small parameters:
// period 10, tolerance 1, lock after 3, timeout after 25.
module tb_tick_period_meter;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic [7:0] period_out;
  logic       period_valid;
  logic       in_tol;
  logic       locked;
  logic       timeout;

  int checks;
  int failures;

  logic       s_pv;
  logic [7:0] s_po;
  logic       s_it;
  logic       s_lk;
  logic       s_to;
  int         extra_pv;
  int         to_at;
  logic       lk_at_to;
  int         to_seen;

  tick_period_meter #(
    .CNT_WIDTH(8),
    .EXPECTED(10),
    .TOLERANCE(1),
    .LOCK_COUNT(3),
    .TIMEOUT_CYCLES(25)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tick_in(tick_in),
    .period_out(period_out),
    .period_valid(period_valid),
    .in_tol(in_tol),
    .locked(locked),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    tick_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // One rise held for 'hold' cycles; next rise starts 'gap' cycles later.
  // Captures outputs one cycle after the rise and watches the gap.
  task automatic tick(input int gap, input int hold);
    tick_in = 1'b1;
    step();
    s_pv = period_valid;
    s_po = period_out;
    s_it = in_tol;
    s_lk = locked;
    s_to = timeout;
    extra_pv = 0;
    to_at    = -1;
    lk_at_to = 1'bx;
    to_seen  = 0;
    for (int i = 1; i < gap; i++) begin
      if (i >= hold) tick_in = 1'b0;
      step();
      if (period_valid) extra_pv++;
      if (timeout) to_seen++;
      if (timeout && to_at < 0) begin
        to_at    = i;
        lk_at_to = locked;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({period_out, period_valid, in_tol, locked, timeout} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got %h exp 000",
               {period_out, period_valid, in_tol, locked, timeout});
    end
  endtask

  task automatic test_steady();
    logic [3:0] exp_lk;
    exp_lk = 4'b1100;
    do_reset();
    tick(10, 1);
    checks++;
    if (s_pv !== 1'b0) begin
      failures++;
      $display("FAIL steady_ref_pv got %0b exp 0", s_pv);
    end
    for (int k = 0; k < 4; k++) begin
      tick(10, 1);
      checks++;
      if (s_pv !== 1'b1 || s_po !== 8'd10 || s_it !== 1'b1) begin
        failures++;
        $display("FAIL steady_strobe%0d got pv=%0b po=%0d it=%0b exp 1/10/1",
                 k, s_pv, s_po, s_it);
      end
      checks++;
      if (s_lk !== exp_lk[k]) begin
        failures++;
        $display("FAIL steady_lock%0d got %0b exp %0b", k, s_lk, exp_lk[k]);
      end
      checks++;
      if (extra_pv !== 0) begin
        failures++;
        $display("FAIL steady_extra%0d got %0d exp 0", k, extra_pv);
      end
    end
  endtask

  task automatic test_out_of_tol();
    do_reset();
    tick(10, 1);
    tick(10, 1);
    tick(10, 1);
    tick(13, 1);
    checks++;
    if (s_lk !== 1'b1) begin
      failures++;
      $display("FAIL oot_lock3 got %0b exp 1", s_lk);
    end
    tick(11, 1);
    checks++;
    if (s_pv !== 1'b1 || s_po !== 8'd13 || s_it !== 1'b0 || s_lk !== 1'b0) begin
      failures++;
      $display("FAIL oot_13 got pv=%0b po=%0d it=%0b lk=%0b exp 1/13/0/0",
               s_pv, s_po, s_it, s_lk);
    end
    tick(10, 1);
    checks++;
    if (s_pv !== 1'b1 || s_po !== 8'd11 || s_it !== 1'b1 || s_lk !== 1'b0) begin
      failures++;
      $display("FAIL oot_11 got pv=%0b po=%0d it=%0b lk=%0b exp 1/11/1/0",
               s_pv, s_po, s_it, s_lk);
    end
  endtask

  task automatic test_held_level();
    do_reset();
    tick(9, 4);
    checks++;
    if (s_pv !== 1'b0 || extra_pv !== 0) begin
      failures++;
      $display("FAIL held_ref got pv=%0b extra=%0d exp 0/0", s_pv, extra_pv);
    end
    for (int k = 0; k < 2; k++) begin
      tick(9, 4);
      checks++;
      if (s_pv !== 1'b1 || s_po !== 8'd9 || extra_pv !== 0) begin
        failures++;
        $display("FAIL held%0d got pv=%0b po=%0d extra=%0d exp 1/9/0",
                 k, s_pv, s_po, extra_pv);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 4; k++) tick(10, 1);
    checks++;
    if (s_lk !== 1'b1) begin
      failures++;
      $display("FAIL tmo_prelock got %0b exp 1", s_lk);
    end
    tick(30, 1);
    checks++;
    if (to_at !== 25 || lk_at_to !== 1'b0) begin
      failures++;
      $display("FAIL tmo_assert got at=%0d lk=%0b exp at=25 lk=0", to_at, lk_at_to);
    end
    tick(10, 1);
    checks++;
    if (s_pv !== 1'b0 || s_to !== 1'b0 || extra_pv !== 0) begin
      failures++;
      $display("FAIL tmo_clear got pv=%0b to=%0b extra=%0d exp 0/0/0",
               s_pv, s_to, extra_pv);
    end
    tick(10, 1);
    checks++;
    if (s_pv !== 1'b1 || s_po !== 8'd10 || s_to !== 1'b0) begin
      failures++;
      $display("FAIL tmo_resume got pv=%0b po=%0d to=%0b exp 1/10/0",
               s_pv, s_po, s_to);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    tick(10, 1);
    tick(25, 1);
    checks++;
    if (to_seen !== 0) begin
      failures++;
      $display("FAIL bound_gap_to got %0d exp 0", to_seen);
    end
    tick(10, 1);
    checks++;
    if (s_pv !== 1'b1 || s_po !== 8'd25 || s_to !== 1'b0 || s_it !== 1'b0) begin
      failures++;
      $display("FAIL bound_25 got pv=%0b po=%0d to=%0b it=%0b exp 1/25/0/0",
               s_pv, s_po, s_to, s_it);
    end
    checks++;
    if (to_seen !== 0) begin
      failures++;
      $display("FAIL bound_after_to got %0d exp 0", to_seen);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 4; k++) tick(10, 1);
    tick_in = 1'b1;
    step();
    tick_in = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({period_out, period_valid, in_tol, locked, timeout} !== 12'h000) begin
      failures++;
      $display("FAIL midrst_outputs got %h exp 000",
               {period_out, period_valid, in_tol, locked, timeout});
    end
    tick(7, 1);
    checks++;
    if (s_pv !== 1'b0 || extra_pv !== 0) begin
      failures++;
      $display("FAIL midrst_ref got pv=%0b extra=%0d exp 0/0", s_pv, extra_pv);
    end
    tick(7, 1);
    checks++;
    if (s_pv !== 1'b1 || s_po !== 8'd7) begin
      failures++;
      $display("FAIL midrst_7 got pv=%0b po=%0d exp 1/7", s_pv, s_po);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    tick_in  = 1'b0;
    test_reset();
    test_steady();
    test_out_of_tol();
    test_held_level();
    test_timeout();
    test_boundary();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
